// File: rtl/gpr_result_checker.sv
// Self-check monitor: shadows watched GPRs from the register-file write port and flags PASS/FAIL.
// Optional per-channel write-data capture is built when GPR_CHK_CAPTURE_EN is defined.
module gpr_result_checker #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_CHK    = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rf_we,
  input  logic [REG_AW-1:0]         rf_waddr,
  input  logic [DATA_W-1:0]         rf_wdata,
  input  logic                      cfg_we,
  input  logic [IDX_W-1:0]          cfg_idx,
  input  logic                      cfg_en,
  input  logic [REG_AW-1:0]         cfg_reg,
  input  logic [DATA_W-1:0]         cfg_exp,
  input  logic                      start,
  input  logic                      clr,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [NUM_CHK-1:0]        match_mask,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic [NUM_CHK*DATA_W-1:0] cap_data
);

  localparam int unsigned SCNT_W = $clog2(STABLE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STABLE = 3'd2,
    S_PASS   = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [NUM_CHK-1:0]             chk_en;
  logic [NUM_CHK-1:0][REG_AW-1:0] chk_reg;
  logic [NUM_CHK-1:0][DATA_W-1:0] chk_exp;
  logic [NUM_CHK-1:0][DATA_W-1:0] shadow;
  logic [NUM_CHK-1:0]             match;
  logic                           all_match;
  logic                           cfg_acc;
  logic                           rf_hit;

  logic [SCNT_W-1:0] scnt, scnt_nxt;
  logic [CNT_W-1:0]  cnt_nxt, cnt_inc;
  logic              tmo_hit;
  logic              busy_nxt, done_nxt, pass_nxt, timeout_nxt;

  assign cfg_acc = cfg_we && (state == S_IDLE);
  assign rf_hit  = rf_we && (rf_waddr != REG_AW'(0));

  // Channel configuration and shadow tracking; shadows follow writes in every state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_en  <= '0;
      chk_reg <= '0;
      chk_exp <= '0;
      shadow  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CHK; i++) begin
        if (cfg_acc && (cfg_idx == IDX_W'(i))) begin
          chk_en[i]  <= cfg_en;
          chk_reg[i] <= cfg_reg;
          chk_exp[i] <= cfg_exp;
        end
        if (rf_hit && (chk_reg[i] == rf_waddr)) begin
          shadow[i] <= rf_wdata;
        end
      end
    end
  end

  // A channel watching $0 sees the hardwired zero, not a stale shadow
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NUM_CHK; i++) begin
      match[i] = !chk_en[i] ||
                 (((chk_reg[i] == REG_AW'(0)) ? DATA_W'(0) : shadow[i]) == chk_exp[i]);
    end
  end

  assign all_match = &match;
  assign cnt_inc   = (cycle_cnt == {CNT_W{1'b1}}) ? cycle_cnt : cycle_cnt + CNT_W'(1);
  assign tmo_hit   = (cycle_cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and counter update; counters only advance while staying in RUN/STABLE
  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    cnt_nxt   = cycle_cnt;
    if (clr) begin
      state_nxt = S_IDLE;
      scnt_nxt  = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_RUN;
            scnt_nxt  = '0;
            cnt_nxt   = '0;
          end
        end
        S_RUN: begin
          cnt_nxt = cnt_inc;
          if (all_match) begin
            state_nxt = S_STABLE;
            scnt_nxt  = SCNT_W'(1);
          end
          if (tmo_hit) begin
            state_nxt = S_FAIL;
            cnt_nxt   = cycle_cnt;
          end
        end
        S_STABLE: begin
          cnt_nxt = cnt_inc;
          if (!all_match) begin
            state_nxt = S_RUN;
            scnt_nxt  = '0;
          end else if (scnt == SCNT_W'(STABLE_CYC)) begin
            state_nxt = S_PASS;
            cnt_nxt   = cycle_cnt;
          end else begin
            scnt_nxt = scnt + SCNT_W'(1);
          end
          if (tmo_hit && (state_nxt != S_PASS)) begin
            state_nxt = S_FAIL;
            cnt_nxt   = cycle_cnt;
          end
        end
        S_PASS, S_FAIL: begin
          state_nxt = state;
        end
        default: begin
          state_nxt = S_IDLE;
          scnt_nxt  = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Status decode from the next state so the registered flags line up with the state
  always_comb begin
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    pass_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    case (state_nxt)
      S_RUN, S_STABLE: busy_nxt = 1'b1;
      S_PASS: begin
        done_nxt = 1'b1;
        pass_nxt = 1'b1;
      end
      S_FAIL: begin
        done_nxt    = 1'b1;
        timeout_nxt = 1'b1;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt       <= '0;
      cycle_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      match_mask <= '0;
    end else begin
      scnt       <= scnt_nxt;
      cycle_cnt  <= cnt_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      timeout    <= timeout_nxt;
      match_mask <= match;
    end
  end

`ifdef GPR_CHK_CAPTURE_EN
  logic [NUM_CHK-1:0][DATA_W-1:0] cap_q;

  // Last write seen by each channel, kept for post-mortem on FAIL
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CHK; i++) begin
        if (rf_hit && (chk_reg[i] == rf_waddr)) begin
          cap_q[i] <= rf_wdata;
        end
      end
    end
  end

  assign cap_data = cap_q;
`else
  assign cap_data = '0;
`endif

endmodule

// File: tb/tb_gpr_result_checker.sv
// Directed bench for gpr_result_checker; a monitor scores every done rise against a queue of expectations.
module tb_gpr_result_checker;

  logic         clk, rst;
  logic         rf_we, cfg_we, cfg_en, start, clr;
  logic [4:0]   rf_waddr, cfg_reg;
  logic [31:0]  rf_wdata, cfg_exp;
  logic [1:0]   cfg_idx;
  logic         busy, done, pass, timeout;
  logic [3:0]   match_mask;
  logic [15:0]  cycle_cnt;
  logic [127:0] cap_data;

  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  logic done_d = 1'b0;

  typedef struct {
    logic        pass;
    logic        tmo;
    int          edge_at;
    logic        use_cnt;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  gpr_result_checker #(
    .DATA_W(32), .REG_AW(5), .NUM_CHK(4), .IDX_W(2),
    .STABLE_CYC(4), .TIMEOUT(64), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_reg(cfg_reg), .cfg_exp(cfg_exp),
    .start(start), .clr(clr),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .match_mask(match_mask), .cycle_cnt(cycle_cnt), .cap_data(cap_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one queued expectation per done rise
  always @(negedge clk) begin
    exp_t e;
    if (rst && done && !done_d) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_pass", 64'(pass), 64'(e.pass));
        chk("sb_timeout", 64'(timeout), 64'(e.tmo));
        chk("sb_done_edge", 64'(edge_n), 64'(e.edge_at));
        if (e.use_cnt) chk("sb_cycle_cnt", 64'(cycle_cnt), 64'(e.cnt));
      end
    end
    done_d = done;
  end

  task automatic push_exp(input logic p, input logic t, input int e, input logic uc, input logic [15:0] c);
    exp_t x;
    x.pass = p; x.tmo = t; x.edge_at = e; x.use_cnt = uc; x.cnt = c;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_ch(input logic [1:0] idx, input logic en, input logic [4:0] r, input logic [31:0] e);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_reg = r; cfg_exp = e;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    tick();
    rf_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Idle until the next driven input will be sampled at edge e
  task automatic wait_to(input int e);
    while (edge_n < e - 1) tick();
  endtask

  task automatic wait_done(input int lim, input string name);
    int n = 0;
    while (!done && n < lim) begin
      tick();
      n++;
    end
    if (!done) chk(name, 64'd0, 64'd1);
  endtask

  initial begin
    int s;
    rst = 1'b0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_reg = '0; cfg_exp = '0;
    start = 1'b0; clr = 1'b0;

    // Reset state
    #23;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_match_mask", 64'(match_mask), 64'd0);
    chk("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    chk("rst_cap_lo", cap_data[63:0], 64'd0);
    #5 rst = 1'b1;
    tick();

    // Single channel: $16 == 0xAB written at start+10, pass at start+15
    cfg_ch(2'd0, 1'b1, 5'd16, 32'h0000_00AB);
    s = edge_n + 1;
    push_exp(1'b1, 1'b0, s + 15, 1'b0, 16'd0);
    do_start();
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_cnt0", 64'(cycle_cnt), 64'd0);
    wait_to(s + 10);
    rf_write(5'd16, 32'h0000_00AB);
    wait_done(40, "single_wait");
    do_clr();
    chk("clr_done", 64'(done), 64'd0);

    // Glitch: match, disturb, rematch; a config write mid-run must be ignored
    rf_write(5'd16, 32'h0);
    s = edge_n + 1;
    push_exp(1'b1, 1'b0, s + 19, 1'b0, 16'd0);
    do_start();
    wait_to(s + 2);
    cfg_ch(2'd0, 1'b1, 5'd16, 32'h0000_0012);
    wait_to(s + 10);
    rf_write(5'd16, 32'h0000_00AB);
    wait_to(s + 12);
    rf_write(5'd16, 32'h0000_0012);
    wait_to(s + 14);
    rf_write(5'd16, 32'h0000_00AB);
    wait_done(40, "glitch_wait");
    do_clr();

    // Multi-channel with shared register and one disabled channel
    cfg_ch(2'd0, 1'b1, 5'd16, 32'd5);
    cfg_ch(2'd1, 1'b1, 5'd17, 32'd7);
    cfg_ch(2'd2, 1'b1, 5'd16, 32'd5);
    cfg_ch(2'd3, 1'b0, 5'd0, 32'd0);
    s = edge_n + 1;
    push_exp(1'b1, 1'b0, s + 11, 1'b0, 16'd0);
    do_start();
    wait_to(s + 3);
    rf_write(5'd17, 32'd7);
    chk("mm_before", 64'(match_mask), 64'h8);
    tick();
    chk("mm_ch1", 64'(match_mask), 64'hA);
    wait_to(s + 6);
    rf_write(5'd16, 32'd5);
    tick();
    chk("mm_all", 64'(match_mask), 64'hF);
    wait_done(40, "multi_wait");
    do_clr();

    // Timeout: expected value never appears
    cfg_ch(2'd0, 1'b1, 5'd16, 32'h99);
    s = edge_n + 1;
    push_exp(1'b0, 1'b1, s + 64, 1'b1, 16'd63);
    do_start();
    wait_done(100, "timeout_wait");
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fail_hold_timeout", 64'(timeout), 64'd1);
    chk("fail_hold_pass", 64'(pass), 64'd0);
    chk("fail_hold_cnt", 64'(cycle_cnt), 64'd63);
    do_clr();
    chk("fail_clr_timeout", 64'(timeout), 64'd0);
    chk("fail_clr_cnt", 64'(cycle_cnt), 64'd0);

    // Channel on $0 with writes to $0; other channels disabled
    cfg_ch(2'd0, 1'b0, 5'd16, 32'h0);
    cfg_ch(2'd1, 1'b0, 5'd17, 32'h0);
    cfg_ch(2'd2, 1'b0, 5'd16, 32'h0);
    cfg_ch(2'd3, 1'b1, 5'd0, 32'h0);
    rf_write(5'd0, 32'h55);
    s = edge_n + 1;
    push_exp(1'b1, 1'b0, s + 5, 1'b0, 16'd0);
    do_start();
    rf_write(5'd0, 32'h55);
    wait_done(20, "zero_wait");

    // clr and start together from PASS: back to IDLE and stays there
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    chk("clrstart_done", 64'(done), 64'd0);
    tick();
    chk("clrstart_busy", 64'(busy), 64'd0);

    // Asynchronous reset while in STABLE
    do_start();
    tick(); tick();
    chk("stable_busy", 64'(busy), 64'd1);
    chk("stable_cnt", 64'(cycle_cnt), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_pass", 64'(pass), 64'd0);
    chk("arst_timeout", 64'(timeout), 64'd0);
    chk("arst_match_mask", 64'(match_mask), 64'd0);
    chk("arst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    #10 rst = 1'b1;
    tick();

    // Capture of the last write per channel
    cfg_ch(2'd0, 1'b1, 5'd16, 32'h0);
    rf_write(5'd16, 32'h0000_DEAD);
    rf_write(5'd16, 32'h0000_BEEF);
`ifdef GPR_CHK_CAPTURE_EN
    chk("cap_ch0", 64'(cap_data[31:0]), 64'h0000_BEEF);
    chk("cap_ch1", 64'(cap_data[63:32]), 64'd0);
`else
    chk("cap_off_lo", cap_data[63:0], 64'd0);
    chk("cap_off_hi", cap_data[127:64], 64'd0);
`endif

    tick(); tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
